// File: rtl/mem_pkg.sv
// mem_pkg: shared request types for the ram request issuer.
// Address and data are fixed 16-bit quantities.
package mem_pkg;

   localparam int MEM_ADDR_W = 16;

   typedef logic [15:0] addr_t;
   typedef logic [15:0] data_t;

   typedef struct packed {
      logic  we;
      addr_t addr;
      data_t data;
   } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: in-order request FIFO, DEPTH a power of two.
// Pointers carry one extra bit so full and empty differ.
module mem_req_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  mem_req_t               din,
   output mem_req_t               head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

   mem_req_t    mem [DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        do_push;
   logic        do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = wp - rp;
   assign full    = count == CAP;
   assign empty   = count == '0;
   assign head    = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wp[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push)
            wp <= wp + (AW+1)'(1);
         if (do_pop)
            rp <= rp + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/mem_req_issuer.sv
// mem_req_issuer: buffers requests, issues in order onto ram ports.
// Define MEM_REQ_ISSUER_STATS_EN for issue/stall counters.
module mem_req_issuer
   import mem_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int MAX_RD_OUT = 4,
   parameter int MAX_WR_OUT = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  req_valid,
   output logic  req_ready,
   input  logic  req_we,
   input  addr_t req_addr,
   input  data_t req_data,
   output logic  wr_en,
   output addr_t wr_address,
   output data_t wr_data,
   input  logic  wr_ret_ack,
   input  addr_t wr_ret_address,
   output logic  rd_en,
   output addr_t rd_address,
   input  logic  rd_ret_ack,
   input  addr_t rd_ret_address,
   input  data_t rd_ret_data,
   output logic  resp_valid,
   output addr_t resp_addr,
   output data_t resp_data,
   output logic  idle,
   output logic  err
`ifdef MEM_REQ_ISSUER_STATS_EN
   ,
   output logic [31:0] stat_rd_issued,
   output logic [31:0] stat_wr_issued,
   output logic [31:0] stat_stall_cycles
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = $clog2(MAX_RD_OUT + 1);
   localparam int WW = $clog2(MAX_WR_OUT + 1);

   mem_req_t      push_req;
   mem_req_t      head;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_nxt;
   logic [RW-1:0] rd_out;
   logic [RW-1:0] rd_nxt;
   logic [WW-1:0] wr_out;
   logic [WW-1:0] wr_nxt;
   logic          rd_iss;
   logic          wr_iss;
   logic          rd_bad;
   logic          wr_bad;
   logic          unused_ok;

   // req_ready already mirrors not-full; full is kept for symmetry
   assign unused_ok = ^{wr_ret_address, full};

   assign push     = req_valid & req_ready;
   assign push_req = '{we: req_we, addr: req_addr, data: req_data};

   mem_req_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (push_req),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      pop = 1'b0;
      if (!empty) begin
         if (head.we)
            pop = wr_out < WW'(MAX_WR_OUT);
         else
            pop = rd_out < RW'(MAX_RD_OUT);
      end
   end

   assign wr_iss  = pop & head.we;
   assign rd_iss  = pop & ~head.we;
   assign cnt_nxt = count + CW'(push) - CW'(pop);

   always_comb begin
      rd_nxt = rd_out;
      rd_bad = 1'b0;
      if (rd_ret_ack && rd_out == '0)
         rd_bad = 1'b1;
      else if (rd_ret_ack)
         rd_nxt = rd_out - RW'(1);
      if (rd_iss)
         rd_nxt = rd_nxt + RW'(1);
   end

   always_comb begin
      wr_nxt = wr_out;
      wr_bad = 1'b0;
      if (wr_ret_ack && wr_out == '0)
         wr_bad = 1'b1;
      else if (wr_ret_ack)
         wr_nxt = wr_out - WW'(1);
      if (wr_iss)
         wr_nxt = wr_nxt + WW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready  <= 1'b1;
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_data    <= '0;
         rd_en      <= 1'b0;
         rd_address <= '0;
         resp_valid <= 1'b0;
         resp_addr  <= '0;
         resp_data  <= '0;
         rd_out     <= '0;
         wr_out     <= '0;
         idle       <= 1'b1;
         err        <= 1'b0;
      end else begin
         req_ready  <= cnt_nxt != CW'(DEPTH);
         wr_en      <= wr_iss;
         rd_en      <= rd_iss;
         if (wr_iss) begin
            wr_address <= head.addr;
            wr_data    <= head.data;
         end
         if (rd_iss)
            rd_address <= head.addr;
         resp_valid <= rd_ret_ack;
         if (rd_ret_ack) begin
            resp_addr <= rd_ret_address;
            resp_data <= rd_ret_data;
         end
         rd_out <= rd_nxt;
         wr_out <= wr_nxt;
         idle   <= cnt_nxt == '0 && rd_nxt == '0
                   && wr_nxt == '0;
         if (rd_bad || wr_bad)
            err <= 1'b1;
      end
   end

`ifdef MEM_REQ_ISSUER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rd_issued    <= '0;
         stat_wr_issued    <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (rd_iss)
            stat_rd_issued <= stat_rd_issued + 32'd1;
         if (wr_iss)
            stat_wr_issued <= stat_wr_issued + 32'd1;
         if (!empty && !pop)
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_issuer.sv
// tb_mem_req_issuer: directed and random checks against a
// queue-based reference model of the request issuer.
module tb_mem_req_issuer;
   import mem_pkg::*;

   localparam int DEPTH = 8;
   localparam int MRD   = 4;
   localparam int MWR   = 1;

   logic  clk;
   logic  rst_n;
   logic  req_valid;
   logic  req_ready;
   logic  req_we;
   addr_t req_addr;
   data_t req_data;
   logic  wr_en;
   addr_t wr_address;
   data_t wr_data;
   logic  wr_ret_ack;
   addr_t wr_ret_address;
   logic  rd_en;
   addr_t rd_address;
   logic  rd_ret_ack;
   addr_t rd_ret_address;
   data_t rd_ret_data;
   logic  resp_valid;
   addr_t resp_addr;
   data_t resp_data;
   logic  idle;
   logic  err;
`ifdef MEM_REQ_ISSUER_STATS_EN
   logic [31:0] stat_rd_issued;
   logic [31:0] stat_wr_issued;
   logic [31:0] stat_stall_cycles;
`endif

   mem_req_issuer #(
      .DEPTH      (DEPTH),
      .MAX_RD_OUT (MRD),
      .MAX_WR_OUT (MWR)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .wr_en          (wr_en),
      .wr_address     (wr_address),
      .wr_data        (wr_data),
      .wr_ret_ack     (wr_ret_ack),
      .wr_ret_address (wr_ret_address),
      .rd_en          (rd_en),
      .rd_address     (rd_address),
      .rd_ret_ack     (rd_ret_ack),
      .rd_ret_address (rd_ret_address),
      .rd_ret_data    (rd_ret_data),
      .resp_valid     (resp_valid),
      .resp_addr      (resp_addr),
      .resp_data      (resp_data),
      .idle           (idle),
      .err            (err)
`ifdef MEM_REQ_ISSUER_STATS_EN
      ,
      .stat_rd_issued    (stat_rd_issued),
      .stat_wr_issued    (stat_wr_issued),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // reference model: request queue plus outstanding counts
   mem_req_t q[$];
   int    m_rd, m_wr;
   bit    m_ready, m_idle, m_err;
   bit    e_wr_en, e_rd_en, e_rv;
   addr_t e_wa, e_ra, e_pa;
   data_t e_wd, e_pd;
   int    m_st_rd, m_st_wr, m_st_stall;

   // bench-side ram
   addr_t ram_rd_q[$];
   addr_t ram_wr_q[$];
   data_t ram [64];
   bit    auto_ack;

   task automatic m_reset();
      q.delete();
      m_rd = 0; m_wr = 0;
      m_ready = 1; m_idle = 1; m_err = 0;
      e_wr_en = 0; e_rd_en = 0; e_rv = 0;
      e_wa = 0; e_ra = 0; e_pa = 0;
      e_wd = 0; e_pd = 0;
      m_st_rd = 0; m_st_wr = 0; m_st_stall = 0;
      ram_rd_q.delete();
      ram_wr_q.delete();
   endtask

   task automatic model_edge();
      mem_req_t h, r;
      bit pop, push;
      pop = 0;
      h = '0;
      if (q.size() > 0) begin
         h = q[0];
         pop = h.we ? (m_wr < MWR) : (m_rd < MRD);
         if (!pop) m_st_stall++;
      end
      push = req_valid && m_ready;
      e_wr_en = pop && h.we;
      e_rd_en = pop && !h.we;
      if (e_wr_en) begin
         e_wa = h.addr; e_wd = h.data; m_st_wr++;
      end
      if (e_rd_en) begin
         e_ra = h.addr; m_st_rd++;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         r.we = req_we; r.addr = req_addr; r.data = req_data;
         q.push_back(r);
      end
      if (rd_ret_ack) begin
         if (m_rd == 0) m_err = 1;
         else m_rd--;
      end
      if (wr_ret_ack) begin
         if (m_wr == 0) m_err = 1;
         else m_wr--;
      end
      if (e_rd_en) m_rd++;
      if (e_wr_en) m_wr++;
      e_rv = rd_ret_ack;
      if (rd_ret_ack) begin
         e_pa = rd_ret_address; e_pd = rd_ret_data;
      end
      m_ready = q.size() < DEPTH;
      m_idle = q.size() == 0 && m_rd == 0 && m_wr == 0;
      if (e_wr_en) begin
         ram[e_wa[5:0]] = e_wd;
         ram_wr_q.push_back(e_wa);
      end
      if (e_rd_en) ram_rd_q.push_back(e_ra);
   endtask

   task automatic check_all();
      chk("req_ready", req_ready, m_ready);
      chk("wr_en", wr_en, e_wr_en);
      chk("wr_address", wr_address, e_wa);
      chk("wr_data", wr_data, e_wd);
      chk("rd_en", rd_en, e_rd_en);
      chk("rd_address", rd_address, e_ra);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_addr", resp_addr, e_pa);
      chk("resp_data", resp_data, e_pd);
      chk("idle", idle, m_idle);
      chk("err", err, m_err);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic clr_ack();
      rd_ret_ack = 0;
      wr_ret_ack = 0;
   endtask

   task automatic ack_rd(int i);
      addr_t a;
      a = ram_rd_q[i];
      ram_rd_q.delete(i);
      rd_ret_ack = 1;
      rd_ret_address = a;
      rd_ret_data = ram[a[5:0]];
   endtask

   task automatic ack_wr();
      wr_ret_ack = 1;
      wr_ret_address = ram_wr_q.pop_front();
   endtask

   task automatic drive_ram();
      clr_ack();
      if (!auto_ack) return;
      if (ram_rd_q.size() > 0 && $urandom_range(0, 2) == 0)
         ack_rd($urandom_range(0, ram_rd_q.size() - 1));
      if (ram_wr_q.size() > 0 && $urandom_range(0, 2) == 0)
         ack_wr();
   endtask

   task automatic put(bit we, addr_t a, data_t d);
      req_valid = 1; req_we = we;
      req_addr = a; req_data = d;
      tick();
      req_valid = 0;
   endtask

   task automatic drain();
      bit done;
      req_valid = 0;
      auto_ack = 1;
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         drive_ram();
         tick();
         done = m_idle && ram_rd_q.size() == 0
                && ram_wr_q.size() == 0;
      end
      clr_ack();
      auto_ack = 0;
      chk("drain_done", done, 1);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      req_valid = 0; req_we = 0;
      req_addr = 0; req_data = 0;
      wr_ret_address = 0;
      rd_ret_address = 0; rd_ret_data = 0;
      clr_ack();
      auto_ack = 0;
      for (int i = 0; i < 64; i++) ram[i] = '0;
      m_reset();
      rst_n = 1;
      #1 rst_n = 0;
      #1 check_all();
      #20 rst_n = 1;

      // write then read 0x0096
      put(1, 16'h0096, 16'h1234);
      put(0, 16'h0096, 16'h0000);
      chk("wtr_wr_en", wr_en, 1);
      chk("wtr_wr_addr", wr_address, 16'h0096);
      chk("wtr_wr_data", wr_data, 16'h1234);
      tick();
      chk("wtr_rd_en", rd_en, 1);
      chk("wtr_rd_addr", rd_address, 16'h0096);
      ack_rd(0);
      ack_wr();
      tick();
      clr_ack();
      chk("wtr_resp_v", resp_valid, 1);
      chk("wtr_resp_a", resp_addr, 16'h0096);
      chk("wtr_resp_d", resp_data, 16'h1234);
      chk("wtr_idle", idle, 1);

      // fill: reads with no acks until the fifo is full
      for (int i = 0; i < 12; i++) begin
         req_valid = 1; req_we = 0;
         req_addr = 16'h0100 + 16'(i);
         tick();
      end
      req_valid = 0;
      chk("fill_ready", req_ready, 0);
      chk("fill_stall", rd_en, 0);
      tick();
      ack_rd(0);
      tick();
      clr_ack();
      chk("fill_hold", rd_en, 0);
      tick();
      chk("fill_issue", rd_en, 1);
      chk("fill_addr", rd_address, 16'h0104);
      chk("fill_ready1", req_ready, 1);
      drain();

      // order: a stalled write blocks a read behind it
      put(1, 16'h0008, 16'h0808);
      tick();
      put(1, 16'h0010, 16'h1010);
      put(0, 16'h0020, 16'h0000);
      put(1, 16'h0030, 16'h3030);
      tick();
      tick();
      chk("ord_rd_blk", rd_en, 0);
      chk("ord_wr_blk", wr_en, 0);
      ack_wr();
      tick();
      clr_ack();
      tick();
      chk("ord_w10", wr_address, 16'h0010);
      tick();
      chk("ord_r20_en", rd_en, 1);
      chk("ord_r20", rd_address, 16'h0020);
      tick();
      chk("ord_w30_blk", wr_en, 0);
      ack_wr();
      tick();
      clr_ack();
      tick();
      chk("ord_w30_en", wr_en, 1);
      chk("ord_w30", wr_address, 16'h0030);
      drain();

      // simultaneous read issue and read return
      put(0, 16'h0001, 16'h0000);
      tick();
      put(0, 16'h0002, 16'h0000);
      ack_rd(0);
      tick();
      clr_ack();
      chk("sim_rd_en", rd_en, 1);
      chk("sim_busy", idle, 0);
      ack_rd(0);
      tick();
      clr_ack();
      chk("sim_idle", idle, 1);

      // random traffic with out-of-order returns
      auto_ack = 1;
      for (int c = 0; c < 600; c++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_we = 1'($urandom_range(0, 1));
         req_addr = 16'($urandom_range(0, 63));
         req_data = 16'($urandom);
         drive_ram();
         tick();
      end
      drain();

      // unexpected read return
      rd_ret_ack = 1;
      rd_ret_address = 16'h0005;
      rd_ret_data = 16'hdead;
      tick();
      clr_ack();
      chk("err_set", err, 1);
      repeat (3) tick();
      chk("err_sticky", err, 1);

      // reset with three requests queued
      put(1, 16'h0040, 16'h4040);
      tick();
      put(1, 16'h0041, 16'h4141);
      put(1, 16'h0042, 16'h4242);
      put(0, 16'h0043, 16'h0000);
      #2 rst_n = 0;
      m_reset();
      #1;
      check_all();
      chk("rst_idle", idle, 1);
      chk("rst_err", err, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1;
      repeat (6) tick();
      chk("rst_no_wr", wr_en, 0);
      chk("rst_no_rd", rd_en, 0);
      wr_ret_ack = 1;
      wr_ret_address = 16'h0041;
      tick();
      clr_ack();
      chk("rst_stale_ack", err, 1);

`ifdef MEM_REQ_ISSUER_STATS_EN
      chk("st_rd", stat_rd_issued, 32'(m_st_rd));
      chk("st_wr", stat_wr_issued, 32'(m_st_wr));
      chk("st_stall", stat_stall_cycles, 32'(m_st_stall));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
